// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FiFo drain-side serial transmitter:
// FSM state encodings and a width helper for counters.
package fifo_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Number of bits needed to count 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_counter.sv
// Modulo-BAUD_DIV counter that paces serial bit periods; tick marks the last
// cycle of each bit period.
module baud_counter
    import fifo_serial_tx_pkg::*;
#(
    parameter int BAUD_DIV = 4,
    localparam int CW = clog2_min1(BAUD_DIV)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    output logic          o_tick,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_tick;

    assign w_tick  = (r_count == LAST);
    assign o_tick  = w_tick;
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a show-ahead FiFo and sends each word as a UART-style frame:
// start bit (0), data LSB first, stop bit (1). Line idles high.
//
// state | meaning
// IDLE  | line high; pop when enabled and FiFo not empty
// START | start bit (tx=0) for one bit period
// DATA  | data bits, LSB first, one bit period each
// STOP  | stop bit (tx=1); done pulses in its last cycle
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int BAUD_DIV   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_empty,
    output logic                  o_pop,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = clog2_min1(BAUD_DIV);
    localparam int IW = clog2_min1(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'((BAUD_DIV > 1) ? (BAUD_DIV - 2) : 0);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_idx;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_tick;
    logic [CW-1:0]         w_count;
    logic                  w_pre_last;

    // Gated by reset so the strobe cannot leak out while the block is held in reset.
    assign w_pop = i_reset && (r_state == ST_IDLE) && i_enable && !i_empty;

    assign w_pre_last = (BAUD_DIV > 1) && (w_count == PRE_LAST);

    baud_counter #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_clear (r_state == ST_IDLE),
        .o_tick  (w_tick),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_pop) begin
                        r_shift <= i_din;
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_idx == LAST_BIT) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                            // With one cycle per bit the stop bit is also its own last cycle.
                            r_done  <= (BAUD_DIV == 1);
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_done  <= w_pre_last;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pop  = w_pop;
    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
